// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the shift-register word sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Upstream valid/ready word handshake; master produces words, slave accepts them.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_dir;

  modport master (output s_valid, output s_data, output s_dir, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_dir, output s_ready);

endinterface

// File: rtl/shift_seq_ctrl_ctr.sv
// Up-counter with synchronous clear, enable and terminal-count compare.
module shift_seq_ctr
  #(
    parameter int W = 3
  ) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
  );

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Word sequencer driving a parallel-load shift register: one load, then WIDTH shifts.
// Optional inter-word idle gap is enabled by defining SHIFT_SEQ_GAP_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
  #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
  ) (
    input  logic                 clk,
    input  logic                 rst,
    shift_seq_ctrl_if.slave      s,
    input  logic                 pause_i,
    output logic                 sr_en_shift_o,
    output logic                 sr_load_o,
    output logic                 sr_right_left_o,
    output logic [WIDTH-1:0]     sr_data_in_o,
    output logic                 bit_valid_o,
    output logic                 bit_last_o,
    output logic                 busy_o
  );

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_TC = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_dir_q, hold_dir_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_last_q, bit_last_d;
  logic             bit_clr, bit_en, bit_tc;

`ifdef SHIFT_SEQ_GAP_EN
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_TC = GW'((GAP > 0) ? GAP - 1 : 0);
  logic gap_clr, gap_en, gap_tc;

  shift_seq_ctr #(.W(GW)) u_gap_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (gap_clr),
    .en_i     (gap_en),
    .tc_val_i (GAP_TC),
    .tc_o     (gap_tc)
  );
`endif

  shift_seq_ctr #(.W(CW)) u_bit_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (bit_clr),
    .en_i     (bit_en),
    .tc_val_i (BIT_TC),
    .tc_o     (bit_tc)
  );

  always_comb begin
    state_d       = state_q;
    hold_data_d   = hold_data_q;
    hold_dir_d    = hold_dir_q;
    sr_en_shift_o = 1'b0;
    sr_load_o     = 1'b0;
    s.s_ready     = 1'b0;
    bit_clr       = 1'b0;
    bit_en        = 1'b0;
`ifdef SHIFT_SEQ_GAP_EN
    gap_clr       = 1'b0;
    gap_en        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        s.s_ready = 1'b1;
        if (s.s_valid) begin
          hold_data_d = s.s_data;
          hold_dir_d  = s.s_dir;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (!pause_i) begin
          sr_en_shift_o = 1'b1;
          sr_load_o     = 1'b1;
          bit_clr       = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        if (!pause_i) begin
          sr_en_shift_o = 1'b1;
          bit_en        = 1'b1;
          if (bit_tc) begin
`ifdef SHIFT_SEQ_GAP_EN
            if (GAP > 0) begin
              gap_clr = 1'b1;
              state_d = shift_seq_pkg::GAP;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef SHIFT_SEQ_GAP_EN
      shift_seq_pkg::GAP: begin
        gap_en = 1'b1;
        if (gap_tc) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Strobes line up with the shift register's registered out bit.
  assign bit_valid_d = (state_q == SHIFT) && !pause_i;
  assign bit_last_d  = bit_valid_d && bit_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_dir_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_dir_q  <= hold_dir_d;
      bit_valid_q <= bit_valid_d;
      bit_last_q  <= bit_last_d;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign sr_data_in_o    = hold_data_q;
  assign sr_right_left_o = hold_dir_q;
  assign bit_valid_o     = bit_valid_q;
  assign bit_last_o      = bit_last_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural downstream shift register.
module tb_shift_seq_ctrl;

  localparam int W = 8;
`ifdef SHIFT_SEQ_GAP_EN
  localparam int GAP_C = 2;
`else
  localparam int GAP_C = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic pause;
  logic en, ld, rl, bv, bl, busy;
  logic [W-1:0] din;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(W)) sif ();

  shift_seq_ctrl #(.WIDTH(W), .GAP(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .s               (sif),
    .pause_i         (pause),
    .sr_en_shift_o   (en),
    .sr_load_o       (ld),
    .sr_right_left_o (rl),
    .sr_data_in_o    (din),
    .bit_valid_o     (bv),
    .bit_last_o      (bl),
    .busy_o          (busy)
  );

  // Downstream parallel-load shift register driven by the DUT controls.
  logic [W-1:0] sr_q = '0;
  logic         sr_out = 1'b0;
  always @(posedge clk) begin
    if (en) begin
      if (ld) begin
        sr_q <= din;
      end else if (rl) begin
        sr_out <= sr_q[0];
        sr_q   <= sr_q >> 1;
      end else begin
        sr_out <= sr_q[W-1];
        sr_q   <= sr_q << 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word: pause pattern per cycle from acceptance; expected timeline derived
  // by counting unpaused cycles (one load, then W shifts), plus the idle gap.
  task automatic run_word(input logic [W-1:0] data, input logic dir, input int pmode);
    bit pv[0:95];
    bit is_sh[0:95];
    int L, T, D, nsh, j;
    for (int k = 0; k < 96; k++) begin
      pv[k]    = 1'b0;
      is_sh[k] = 1'b0;
    end
    if (pmode == 1) begin
      pv[6] = 1'b1; pv[7] = 1'b1; pv[8] = 1'b1;
    end else if (pmode == 2) begin
      for (int k = 0; k < 40; k++) pv[k] = ($urandom_range(0, 3) == 0);
    end
    L = 1;
    while (pv[L]) L++;
    nsh = 0;
    T   = L;
    for (int k = L + 1; nsh < W; k++) begin
      if (!pv[k]) begin
        is_sh[k] = 1'b1;
        nsh++;
        T = k;
      end
    end
    D = T + 1 + GAP_C;

    @(posedge clk); #1;
    sif.s_valid = 1'b1;
    sif.s_data  = data;
    sif.s_dir   = dir;
    pause       = pv[0];
    @(negedge clk);
    chk("ready_at_accept", sif.s_ready, 1);
    chk("bv_at_accept", bv, 0);

    j = 0;
    for (int k = 1; k <= D; k++) begin
      @(posedge clk); #1;
      sif.s_valid = 1'b0;
      sif.s_data  = W'($urandom);
      sif.s_dir   = 1'($urandom);
      pause       = pv[k];
      @(negedge clk);
      chk("s_ready", sif.s_ready, (k == D));
      chk("busy", busy, (k != D));
      chk("sr_load", ld, (k == L));
      chk("sr_en_shift", en, (k == L) || is_sh[k]);
      chk("bit_valid", bv, is_sh[k-1]);
      chk("bit_last", bl, (k - 1 == T));
      chk("sr_data_in", din, data);
      chk("sr_right_left", rl, dir);
      if (is_sh[k-1]) begin
        chk("sr_out", sr_out, dir ? data[j] : data[W-1-j]);
        j++;
      end
    end
    chk("bit_count", j, W);
  endtask

  task automatic reset_mid_word();
    @(posedge clk); #1;
    sif.s_valid = 1'b1;
    sif.s_data  = 8'h3C;
    sif.s_dir   = 1'b1;
    pause       = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      sif.s_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", sif.s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_load", ld, 0);
    chk("rst_rl", rl, 0);
    chk("rst_din", din, 0);
    chk("rst_bv", bv, 0);
    chk("rst_bl", bl, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_bv", bv, 0);
    chk("post_rst_ready", sif.s_ready, 1);
  endtask

  // Two words with s_valid held high: second acceptance lands GAP cycles after bit_last.
  task automatic queued_words(input logic [W-1:0] w1, input logic [W-1:0] w2);
    logic got[$];
    logic [W-1:0] wv;
    int acc, t_acc2, t_bl, cyc;
    acc = 0; t_acc2 = -1; t_bl = -1; cyc = 0;
    @(posedge clk); #1;
    sif.s_valid = 1'b1;
    sif.s_data  = w1;
    sif.s_dir   = 1'b1;
    pause       = 1'b0;
    while (got.size() < 2 * W && cyc < 60) begin
      @(negedge clk);
      if (sif.s_ready && sif.s_valid) begin
        acc++;
        if (acc == 2) t_acc2 = cyc;
      end
      if (bl && t_bl < 0) t_bl = cyc;
      if (bv) got.push_back(sr_out);
      if (busy && acc == 1) chk("q_din_hold", din, w1);
      @(posedge clk); #1;
      if (acc == 1) sif.s_data = w2;
      if (acc >= 2) sif.s_valid = 1'b0;
      cyc++;
    end
    sif.s_valid = 1'b0;
    chk("q_bits_total", got.size(), 2 * W);
    chk("q_accept_delay", t_acc2 - t_bl, GAP_C);
    for (int i = 0; i < 2 * W && i < got.size(); i++) begin
      wv = (i < W) ? w1 : w2;
      chk("q_bit", got[i], wv[i % W]);
    end
    repeat (GAP_C + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    pause       = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_dir   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", sif.s_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_en", en, 0);
    chk("reset_load", ld, 0);
    chk("reset_rl", rl, 0);
    chk("reset_din", din, 0);
    chk("reset_bv", bv, 0);
    chk("reset_bl", bl, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    run_word(8'hA5, shift_seq_pkg::DIR_RIGHT, 0);
    run_word(8'h81, shift_seq_pkg::DIR_LEFT, 0);
    run_word(8'hA5, shift_seq_pkg::DIR_RIGHT, 1);
    reset_mid_word();
    run_word(8'hC3, shift_seq_pkg::DIR_RIGHT, 0);
    queued_words(8'h5A, 8'hE1);
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      run_word(W'($urandom), 1'($urandom), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
